// File: rtl/qpsk_mod_framer_pkg.sv
// Shared types and helpers for the QPSK framer: FSM states, the sc16 sample,
// the pilot LFSR taps and the Gray QPSK mapper.
package qpsk_mod_pkg;

  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD} state_t;

  typedef struct packed {
    logic signed [15:0] i;
    logic signed [15:0] q;
  } sc16_t;

  localparam logic [6:0] LFSR_TAPS     = 7'b1100000;
  localparam int         SYMS_PER_WORD = 16;

  // bits[0] selects the I sign, bits[1] the Q sign; a 1 gives -amp.
  function automatic sc16_t qpsk_map(input logic [1:0] bits, input logic signed [15:0] amp);
    sc16_t s;
    s.i = bits[0] ? -amp : amp;
    s.q = bits[1] ? -amp : amp;
    return s;
  endfunction

endpackage

// File: rtl/qpsk_mod_framer_if.sv
// Payload-in / sample-out AXI-stream pair of the framer. The slave view is the
// framer itself; the master view is whatever feeds and drains it.
interface qpsk_mod_framer_if;
  logic [31:0] in_tdata;
  logic        in_tlast;
  logic        in_tvalid;
  logic        in_tready;
  logic [31:0] out_tdata;
  logic        out_tlast;
  logic        out_tvalid;
  logic        out_tready;

  modport master (
    output in_tdata, in_tlast, in_tvalid, out_tready,
    input  in_tready, out_tdata, out_tlast, out_tvalid
  );

  modport slave (
    input  in_tdata, in_tlast, in_tvalid, out_tready,
    output in_tready, out_tdata, out_tlast, out_tvalid
  );
endinterface

// File: rtl/qpsk_mod_framer_lfsr.sv
// PN7 pilot source (x^7+x^6+1, Fibonacci). load returns to SEED; when load and
// step coincide the register lands one step past SEED.
module qpsk_pilot_lfsr
  import qpsk_mod_pkg::*;
#(
  parameter logic [6:0] SEED = 7'h7F
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic step_i,
  output logic bit_o
);
  logic [6:0] lfsr_q, lfsr_d, base;

  always_comb begin
    base   = load_i ? SEED : lfsr_q;
    lfsr_d = step_i ? {base[5:0], ^(base & LFSR_TAPS)} : base;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;

  assign bit_o = lfsr_q[6];
endmodule

// File: rtl/qpsk_mod_framer.sv
// QPSK transmit framer: BPSK pilot preamble from a PN7 LFSR, then Gray-mapped
// payload symbols, 16 per 32-bit input word, through one sc16 output register.
module qpsk_mod_framer
  import qpsk_mod_pkg::*;
#(
  parameter int                 PREAMBLE_LEN = 32,
  parameter logic signed [15:0] AMP          = 16'sd11585,
  parameter logic [6:0]         LFSR_SEED    = 7'h7F
) (
  input  logic             axis_data_clk,
  input  logic             axis_data_resetn,
  qpsk_mod_framer_if.slave io
);
  localparam logic [6:0] PIL_LAST = 7'(PREAMBLE_LEN - 1);
  localparam logic [3:0] SYM_LAST = 4'(SYMS_PER_WORD - 1);

  state_t      state_q, state_d;
  logic [6:0]  pil_cnt_q, pil_cnt_d;
  logic [3:0]  sym_cnt_q, sym_cnt_d;
  logic [31:0] shreg_q, shreg_d;
  logic        wlast_q, wlast_d;
  logic        have_q, have_d;
  sc16_t       odata_q, odata_d;
  logic        olast_q, olast_d;
  logic        ovld_q, ovld_d;
  logic        adv, in_rdy, lfsr_load, lfsr_step, pil_bit;

  qpsk_pilot_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (axis_data_clk),
    .rst_n  (axis_data_resetn),
    .load_i (lfsr_load),
    .step_i (lfsr_step),
    .bit_o  (pil_bit)
  );

  // pil_cnt_q is the index of the pilot loaded on the next adv. The final
  // symbol of a frame takes no word: the next frame's first word waits for IDLE.
  assign adv    = !ovld_q || io.out_tready;
  assign in_rdy = adv && ((state_q == PREAMBLE && pil_cnt_q == PIL_LAST) ||
                          (state_q == PAYLOAD && (!have_q || (sym_cnt_q == SYM_LAST && !wlast_q))));

  always_comb begin
    state_d   = state_q;
    pil_cnt_d = pil_cnt_q;
    sym_cnt_d = sym_cnt_q;
    shreg_d   = shreg_q;
    wlast_d   = wlast_q;
    have_d    = have_q;
    odata_d   = odata_q;
    olast_d   = olast_q;
    ovld_d    = ovld_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    case (state_q)
      IDLE: if (adv) begin
        ovld_d  = 1'b0;
        olast_d = 1'b0;
        if (io.in_tvalid) begin
          lfsr_load = 1'b1;
          lfsr_step = 1'b1;
          odata_d   = qpsk_map({2{LFSR_SEED[6]}}, AMP);
          ovld_d    = 1'b1;
          pil_cnt_d = 7'd1;
          state_d   = (PIL_LAST == 7'd0) ? PAYLOAD : PREAMBLE;
        end
      end
      PREAMBLE: if (adv) begin
        lfsr_step = 1'b1;
        odata_d   = qpsk_map({2{pil_bit}}, AMP);
        ovld_d    = 1'b1;
        olast_d   = 1'b0;
        pil_cnt_d = pil_cnt_q + 7'd1;
        if (pil_cnt_q == PIL_LAST) state_d = PAYLOAD;
      end
      PAYLOAD: if (adv) begin
        ovld_d  = 1'b0;
        olast_d = 1'b0;
        if (have_q) begin
          odata_d   = qpsk_map(shreg_q[{sym_cnt_q, 1'b0} +: 2], AMP);
          ovld_d    = 1'b1;
          sym_cnt_d = sym_cnt_q + 4'd1;
          if (sym_cnt_q == SYM_LAST) begin
            have_d = 1'b0;
            if (wlast_q) begin
              olast_d = 1'b1;
              wlast_d = 1'b0;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (in_rdy && io.in_tvalid) begin
      shreg_d   = io.in_tdata;
      wlast_d   = io.in_tlast;
      have_d    = 1'b1;
      sym_cnt_d = 4'd0;
    end
  end

  always_ff @(posedge axis_data_clk or negedge axis_data_resetn)
    if (!axis_data_resetn) begin
      state_q   <= IDLE;
      pil_cnt_q <= '0;
      sym_cnt_q <= '0;
      shreg_q   <= '0;
      wlast_q   <= 1'b0;
      have_q    <= 1'b0;
      odata_q   <= '0;
      olast_q   <= 1'b0;
      ovld_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pil_cnt_q <= pil_cnt_d;
      sym_cnt_q <= sym_cnt_d;
      shreg_q   <= shreg_d;
      wlast_q   <= wlast_d;
      have_q    <= have_d;
      odata_q   <= odata_d;
      olast_q   <= olast_d;
      ovld_q    <= ovld_d;
    end

  assign io.in_tready  = in_rdy;
  assign io.out_tdata  = odata_q;
  assign io.out_tlast  = olast_q;
  assign io.out_tvalid = ovld_q;
endmodule
